wm_phase_timer: RTL and testbench
=================================

# wm_phase_timer

Parametrised phase timer for the washing-machine controller, the successor to the fixed 4-bit free-running timer. It provides a programmable terminal count, a clock prescaler, one-shot or auto-reload mode, pause/resume and abort, and a registered single-cycle completion pulse. The controller FSM instantiates one per wash phase (fill, wash, rinse, spin) and sequences on `done`.

## Interface
- `WIDTH`, 8: width of the tick counter and terminal count.
- `PRESCALE`, 1: clock cycles per tick, 1 or more. The prescaler width is `$clog2(PRESCALE)`, minimum 1.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: load `load_val` and begin counting.
- `load_val`, in, WIDTH: terminal count in ticks, sampled only when `start` is accepted.
- `auto_reload`, in, 1: sampled together with `load_val`. 1 selects periodic mode; 0 selects one-shot mode.
- `pause`, in, 1: level-sensitive. While high in RUN, counting freezes.
- `abort`, in, 1: return to IDLE immediately.
- `counter`, out, WIDTH: elapsed ticks (registered).
- `remaining`, out, WIDTH: `terminal - counter` (combinational from registers).
- `busy`, out, 1: high in RUN or PAUSE.
- `paused`, out, 1: high in PAUSE.
- `done`, out, 1: registered single-cycle pulse on each terminal event.

## Operation
- **States:** IDLE, RUN, PAUSE, DONE.
- **Reset values:** state IDLE; `counter`, terminal, prescaler and `done` are 0; `busy` and `paused` are 0.
- **Control priority:** `abort` > `start` > `pause`.
- **abort (any state):** next state IDLE; `counter`=0, prescaler=0, `done`=0.
- **start (any state):** latch terminal=`load_val` and mode=`auto_reload`; `counter`=0, prescaler=0; next state RUN. Restart while RUN or PAUSE is legal and discards progress.
- **start with load_val=0:** state goes to DONE, `done` pulses the following cycle, `counter` stays 0. With `auto_reload`=1 the state also goes to DONE (no zero-period oscillation).
- **tick:** asserted in RUN when prescaler==`PRESCALE`-1. On a tick the prescaler clears; otherwise it increments. In PAUSE, IDLE and DONE the prescaler holds.
- **RUN, tick, counter < terminal-1:** `counter`+1.
- **RUN, tick, counter == terminal-1:**
  - One-shot mode: `counter` becomes terminal, `done`=1 for one cycle, next state DONE.
  - Auto-reload mode: `counter` becomes 0, `done`=1 for one cycle, state stays RUN. The period is exactly terminal × `PRESCALE` cycles.
- **RUN with pause=1 (and no start/abort):** next state PAUSE. `counter` and prescaler hold; any tick in that cycle is suppressed.
- **PAUSE with pause=0:** next state RUN; resumes from the held prescaler value with no lost or extra cycles.
- **DONE:** holds `counter`=terminal, `remaining`=0, `busy`=0, until `start` or `abort`.
- **IDLE and DONE:** `pause` is ignored.
- **Arithmetic:** `counter` is unsigned and never exceeds terminal. Terminal `2^WIDTH-1` is legal: one-shot mode finishes at all-ones; auto-reload mode wraps to 0.

## Timing
- Every output except `remaining` is registered; input-to-output latency is 1 cycle.
- With `PRESCALE`=1 and `load_val`=3, `start` sampled at edge 0:
  - Edge 0: RUN, `counter`=0, `busy`=1.
  - Edges 1, 2: `counter`=1, then 2.
  - Edge 3: `counter`=3, `done`=1, state DONE, `busy`=0.
  - Edge 4: `done`=0.
- With `PRESCALE`=N, each `counter` step occurs N edges after the previous one.
- `done` is never high for two consecutive cycles, except in auto-reload mode with terminal=1 and `PRESCALE`=1, where it pulses every cycle.
- Asynchronous `reset` asserted mid-count forces all outputs to their reset values without waiting for a clock edge. Deassertion is synchronised externally, and the block is in IDLE on the first edge after deassertion.
- `start` coincident with a terminal tick: `start` wins; no `done` pulse that cycle.
- `abort` coincident with a terminal tick: `abort` wins; no `done` pulse that cycle.

## Test plan
- **One-shot:** `PRESCALE`=1, `load_val`=5, `auto_reload`=0 → `counter` steps 0..5, `done` high exactly once (5 cycles after start), `busy` falls with it, DONE holds 5.
- **Prescale plus auto-reload:** `PRESCALE`=4, `load_val`=3, `auto_reload`=1 → `done` every 12 cycles for at least 3 periods; `counter` sequence 0,1,2,0…
- **Pause:** pause held 7 cycles mid-count at `counter`=2, `PRESCALE`=4 → `counter` and `remaining` frozen, `paused`=1; on release, total start-to-`done` latency is the nominal value + 7.
- **Zero and max load:** `load_val`=0 → `done` pulses the cycle after start entry, `counter`=0. `WIDTH`=4, `load_val`=15, one-shot → ends at 15, no wrap.
- **Collisions:** `abort` on the terminal tick → IDLE, no `done`; `start` with `load_val`=2 while RUN at `counter`=4 → `counter`=0 next cycle, `done` 2 ticks later.
- **Async reset mid-RUN,** asserted between clock edges → all outputs 0 before the next edge; IDLE after release.

Source files
------------

// File: rtl/wm_phase_timer.sv
// Programmable phase timer for the washing-machine controller: prescaled tick
// counter with one-shot/auto-reload modes, pause/resume, abort and a done pulse.
module wm_phase_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] counter,
  output logic [WIDTH-1:0] remaining,
  output logic             busy,
  output logic             paused,
  output logic             done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] terminal_q, terminal_d;
  logic             mode_q, mode_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      counter_q  <= '0;
      terminal_q <= '0;
      mode_q     <= 1'b0;
      presc_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      terminal_q <= terminal_d;
      mode_q     <= mode_d;
      presc_q    <= presc_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    terminal_d = terminal_q;
    mode_d     = mode_q;
    presc_d    = presc_q;
    done_d     = 1'b0;

    if (abort) begin
      state_d   = IDLE;
      counter_d = '0;
      presc_d   = '0;
    end else if (start) begin
      terminal_d = load_val;
      mode_d     = auto_reload;
      counter_d  = '0;
      presc_d    = '0;
      if (load_val == '0) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if ((state_q == RUN) || (state_q == PAUSE)) begin
      if (pause) begin
        state_d = PAUSE;
      end else begin
        // The release cycle out of PAUSE already counts, so a pause of N
        // sampled cycles delays completion by exactly N cycles.
        state_d = RUN;
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (counter_q == terminal_q - WIDTH'(1)) begin
            done_d = 1'b1;
            if (mode_q) begin
              counter_d = '0;
            end else begin
              counter_d = terminal_q;
              state_d   = DONE;
            end
          end else begin
            counter_d = counter_q + WIDTH'(1);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    end
  end

  assign counter   = counter_q;
  assign remaining = terminal_q - counter_q;
  assign busy      = (state_q == RUN) || (state_q == PAUSE);
  assign paused    = (state_q == PAUSE);
  assign done      = done_q;

endmodule

// File: tb/tb_wm_phase_timer.sv
// Directed bench for wm_phase_timer: three instances (prescale 1, prescale 4,
// 4-bit width) share stimulus; each scenario checks the relevant instance.
module tb_wm_phase_timer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] load_val;
  logic       auto_reload;
  logic       pause;
  logic       abort;

  logic [7:0] aCounter, aRemaining, bCounter, bRemaining;
  logic [3:0] cCounter, cRemaining;
  logic       aBusy, aPaused, aDone, bBusy, bPaused, bDone, cBusy, cPaused, cDone;

  int checks = 0;
  int errors = 0;

  wm_phase_timer #(.WIDTH(8), .PRESCALE(1)) dutA (
    .clk(clk), .reset(reset), .start(start), .load_val(load_val),
    .auto_reload(auto_reload), .pause(pause), .abort(abort),
    .counter(aCounter), .remaining(aRemaining), .busy(aBusy),
    .paused(aPaused), .done(aDone)
  );

  wm_phase_timer #(.WIDTH(8), .PRESCALE(4)) dutB (
    .clk(clk), .reset(reset), .start(start), .load_val(load_val),
    .auto_reload(auto_reload), .pause(pause), .abort(abort),
    .counter(bCounter), .remaining(bRemaining), .busy(bBusy),
    .paused(bPaused), .done(bDone)
  );

  wm_phase_timer #(.WIDTH(4), .PRESCALE(1)) dutC (
    .clk(clk), .reset(reset), .start(start), .load_val(load_val[3:0]),
    .auto_reload(auto_reload), .pause(pause), .abort(abort),
    .counter(cCounter), .remaining(cRemaining), .busy(cBusy),
    .paused(cPaused), .done(cDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic doAbort();
    abort = 1'b1;
    step(1);
    abort = 1'b0;
  endtask

  task automatic doStart(input logic [7:0] val, input logic ar);
    start       = 1'b1;
    load_val    = val;
    auto_reload = ar;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    int expCnt;
    reset       = 1'b1;
    start       = 1'b0;
    load_val    = '0;
    auto_reload = 1'b0;
    pause       = 1'b0;
    abort       = 1'b0;

    // Reset values
    step(1);
    chk("rst_counter", aCounter, 0);
    chk("rst_remaining", aRemaining, 0);
    chk("rst_busy", aBusy, 0);
    chk("rst_paused", aPaused, 0);
    chk("rst_done", aDone, 0);
    reset = 1'b0;
    step(1);
    chk("rst_idle_busy", aBusy, 0);

    // One-shot, prescale 1, load 5
    doStart(8'd5, 1'b0);
    chk("os_start_counter", aCounter, 0);
    chk("os_start_busy", aBusy, 1);
    chk("os_start_remaining", aRemaining, 5);
    for (int i = 1; i <= 4; i++) begin
      step(1);
      chk("os_counter", aCounter, i);
      chk("os_done_low", aDone, 0);
    end
    step(1);
    chk("os_term_counter", aCounter, 5);
    chk("os_term_done", aDone, 1);
    chk("os_term_busy", aBusy, 0);
    step(1);
    chk("os_after_done", aDone, 0);
    chk("os_hold_counter", aCounter, 5);
    chk("os_hold_remaining", aRemaining, 0);
    step(2);
    chk("os_hold2_counter", aCounter, 5);
    chk("os_hold2_done", aDone, 0);
    doAbort();
    chk("abort_counter", aCounter, 0);
    chk("abort_busy", aBusy, 0);

    // Auto-reload, prescale 4, load 3: done every 12 cycles
    doStart(8'd3, 1'b1);
    chk("ar_start_counter", bCounter, 0);
    for (int p = 0; p < 3; p++) begin
      for (int k = 1; k <= 12; k++) begin
        step(1);
        expCnt = (k >= 4 && k < 8) ? 1 : ((k >= 8 && k < 12) ? 2 : 0);
        chk("ar_counter", bCounter, expCnt);
        chk("ar_done", bDone, (k == 12) ? 1 : 0);
        chk("ar_busy", bBusy, 1);
      end
    end
    doAbort();
    chk("ar_abort_busy", bBusy, 0);

    // Pause 7 cycles at counter 2, prescale 4, load 5: done at 20 + 7
    doStart(8'd5, 1'b0);
    step(8);
    chk("pz_pre_counter", bCounter, 2);
    pause = 1'b1;
    for (int k = 9; k <= 15; k++) begin
      step(1);
      chk("pz_paused", bPaused, 1);
      chk("pz_counter", bCounter, 2);
      chk("pz_remaining", bRemaining, 3);
      chk("pz_busy", bBusy, 1);
    end
    pause = 1'b0;
    for (int k = 16; k <= 27; k++) begin
      step(1);
      chk("pz_run_paused", bPaused, 0);
      chk("pz_done", bDone, (k == 27) ? 1 : 0);
    end
    chk("pz_final_counter", bCounter, 5);
    doAbort();

    // Zero load with auto-reload: straight to DONE, single pulse
    doStart(8'd0, 1'b1);
    chk("zero_done", aDone, 1);
    chk("zero_counter", aCounter, 0);
    chk("zero_busy", aBusy, 0);
    step(1);
    chk("zero_done_once", aDone, 0);
    chk("zero_remaining", aRemaining, 0);
    doAbort();

    // Max load on 4-bit instance: finishes at 15 without wrapping
    doStart(8'd15, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      step(1);
      chk("max_counter", cCounter, k);
    end
    step(1);
    chk("max_term_counter", cCounter, 15);
    chk("max_term_done", cDone, 1);
    step(1);
    chk("max_hold_counter", cCounter, 15);
    chk("max_hold_done", cDone, 0);
    chk("max_hold_busy", cBusy, 0);
    doAbort();

    // Abort on the terminal tick wins: no done pulse
    doStart(8'd3, 1'b0);
    step(2);
    chk("col_ab_pre", aCounter, 2);
    doAbort();
    chk("col_ab_done", aDone, 0);
    chk("col_ab_busy", aBusy, 0);
    chk("col_ab_counter", aCounter, 0);
    step(1);
    chk("col_ab_done_late", aDone, 0);

    // Restart while running at counter 4
    doStart(8'd10, 1'b0);
    step(4);
    chk("col_rs_pre", aCounter, 4);
    doStart(8'd2, 1'b0);
    chk("col_rs_counter", aCounter, 0);
    chk("col_rs_remaining", aRemaining, 2);
    step(1);
    chk("col_rs_c1", aCounter, 1);
    chk("col_rs_d1", aDone, 0);
    step(1);
    chk("col_rs_c2", aCounter, 2);
    chk("col_rs_done", aDone, 1);

    // Start coincident with the terminal tick wins: no done
    doStart(8'd3, 1'b0);
    step(2);
    doStart(8'd3, 1'b0);
    chk("col_st_done", aDone, 0);
    chk("col_st_counter", aCounter, 0);
    chk("col_st_busy", aBusy, 1);

    // Asynchronous reset between edges
    doStart(8'd20, 1'b0);
    step(3);
    chk("ar_pre_counter", aCounter, 3);
    #3;
    reset = 1'b1;
    #1;
    chk("async_counter", aCounter, 0);
    chk("async_busy", aBusy, 0);
    chk("async_remaining", aRemaining, 0);
    chk("async_done", aDone, 0);
    chk("async_b_busy", bBusy, 0);
    step(1);
    reset = 1'b0;
    step(1);
    chk("post_rst_busy", aBusy, 0);
    chk("post_rst_counter", aCounter, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
